// File: rtl/mseq_pkg.sv
// mseq_pkg: shared mode constants, FSM state type and width helpers for the seed dispatcher
package mseq_pkg;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_BCAST = 1'b1;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int acc_width(input int dw, input int idw);
    return idw + 3 * dw;
  endfunction
  function automatic int fill_width(input int dw, input int idw);
    return $clog2(acc_width(dw, idw)) + 1;
  endfunction
endpackage

// File: rtl/mseq_dispatch_if.sv
// mseq_dispatch_if: chaotic sample stream in, seed word and per-channel strobes out
interface mseq_dispatch_if #(
  parameter int DATA_WIDTH = 64,
  parameter int INPUT_DATA_WIDTH = 288,
  parameter int N_CH = 4
);
  logic n1_valid;
  logic [DATA_WIDTH-1:0] xn1, yn1, zn1;
  logic [N_CH-1:0] ch_en, ch_ready, mseq_din_vld;
  logic bcast_mode;
  logic [INPUT_DATA_WIDTH-1:0] mseq_din;
  modport slave (
    input n1_valid, xn1, yn1, zn1, ch_en, bcast_mode, ch_ready,
    output mseq_din, mseq_din_vld
  );
  modport master (
    output n1_valid, xn1, yn1, zn1, ch_en, bcast_mode, ch_ready,
    input mseq_din, mseq_din_vld
  );
endinterface

// File: rtl/mseq_pack_acc.sv
// mseq_pack_acc: bit-exact residue accumulator packing {x,y,z} samples into seed words
module mseq_pack_acc
  import mseq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INPUT_DATA_WIDTH = 288
) (
  input  logic clk,
  input  logic rst,
  input  logic n1_valid,
  input  logic [DATA_WIDTH-1:0] xn1,
  input  logic [DATA_WIDTH-1:0] yn1,
  input  logic [DATA_WIDTH-1:0] zn1,
  output logic [INPUT_DATA_WIDTH-1:0] word,
  output logic word_done
);
  localparam int SW = 3 * DATA_WIDTH;
  localparam int AW = acc_width(DATA_WIDTH, INPUT_DATA_WIDTH);
  localparam int FW = fill_width(DATA_WIDTH, INPUT_DATA_WIDTH);
  logic [AW-1:0] acc_q, acc_d, merged;
  logic [FW-1:0] fill_q, fill_d, sum;
  // append the sample right after the live bits; peel off the oldest word once enough bits exist
  always_comb begin
    merged = acc_q | ({xn1, yn1, zn1, INPUT_DATA_WIDTH'(0)} >> fill_q);
    sum = fill_q + FW'(SW);
    word_done = n1_valid && sum >= FW'(INPUT_DATA_WIDTH);
    word = merged[AW-1 -: INPUT_DATA_WIDTH];
    acc_d = !n1_valid ? acc_q : word_done ? merged << INPUT_DATA_WIDTH : merged;
    fill_d = !n1_valid ? fill_q : word_done ? sum - FW'(INPUT_DATA_WIDTH) : sum;
  end
  // residue register, left-aligned with zeros below the fill point
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      fill_q <= '0;
    end else begin
      acc_q <= acc_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/mseq_dispatch.sv
// mseq_dispatch: packs chaotic samples into seed words and hands them to M-sequence channels
module mseq_dispatch
  import mseq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int INPUT_DATA_WIDTH = 288,
  parameter int N_CH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  mseq_dispatch_if.slave bus,
  output logic word_pending,
  output logic overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt
);
  localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic [INPUT_DATA_WIDTH-1:0] word, din_q, din_d, stage_word_q, stage_word_d;
  logic word_done;
  state_t state_q, state_d;
  logic stage_q, stage_d, pending_q, pending_d, ovf_q, ovf_d;
  logic [N_CH-1:0] vld_q, vld_d;
  logic [PW-1:0] ptr_q, ptr_d, tgt;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic hold, bcast, no_en, rr_go, bc_go, go, kill, free, drop_inc;

  mseq_pack_acc #(.DATA_WIDTH(DATA_WIDTH), .INPUT_DATA_WIDTH(INPUT_DATA_WIDTH)) u_acc (
    .clk(clk),
    .rst(rst),
    .n1_valid(bus.n1_valid),
    .xn1(bus.xn1),
    .yn1(bus.yn1),
    .zn1(bus.zn1),
    .word(word),
    .word_done(word_done)
  );

  function automatic logic [PW-1:0] rr_pick(input logic [N_CH-1:0] en, input logic [PW-1:0] p);
    logic [PW:0] s;
    logic [PW-1:0] t;
    t = p;
    for (int k = N_CH - 1; k >= 0; k--) begin
      s = {1'b0, p} + (PW + 1)'(k);
      s = s >= (PW + 1)'(N_CH) ? s - (PW + 1)'(N_CH) : s;
      t = en[s[PW-1:0]] ? s[PW-1:0] : t;
    end
    return t;
  endfunction

  // dispatch decision; a word completing on the dispatch edge is staged so the strobe still carries the old word
  always_comb begin
    hold = state_q == HOLD;
    bcast = bus.bcast_mode == MODE_BCAST;
    no_en = bus.ch_en == '0;
    tgt = rr_pick(bus.ch_en, ptr_q);
    rr_go = !no_en && bus.ch_ready[tgt];
    bc_go = !no_en && (bus.ch_ready & bus.ch_en) == bus.ch_en;
    go = hold && (bcast ? bc_go : rr_go);
    kill = hold && no_en;
    free = !hold || go || kill;
    drop_inc = kill || (word_done && !free);
    state_d = free ? (word_done ? HOLD : IDLE) : state_q;
    stage_d = free && hold && word_done;
    stage_word_d = stage_d ? word : stage_word_q;
    din_d = stage_q ? stage_word_q : (!hold && word_done) ? word : din_q;
    vld_d = !go ? '0 : bcast ? bus.ch_en : N_CH'(1) << tgt;
    ptr_d = go && !bcast ? (tgt == PW'(N_CH - 1) ? '0 : tgt + 1'b1) : ptr_q;
    drop_d = drop_inc && drop_q != '1 ? drop_q + 1'b1 : drop_q;
    ovf_d = ovf_q || drop_inc;
    pending_d = state_d == HOLD;
  end

  // IDLE/HOLD state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q <= '0;
      stage_q <= 1'b0;
      stage_word_q <= '0;
      vld_q <= '0;
      ptr_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q <= din_d;
      stage_q <= stage_d;
      stage_word_q <= stage_word_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
      pending_q <= pending_d;
    end
  end

  assign bus.mseq_din = din_q;
  assign bus.mseq_din_vld = vld_q;
  assign word_pending = pending_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_mseq_dispatch.sv
// tb_mseq_dispatch: directed checks of packing, round-robin, broadcast, drops and reset
module tb_mseq_dispatch;
  import mseq_pkg::*;
  localparam int DW = 64;
  localparam int IDW = 288;
  localparam int N = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic word_pending, overflow;
  logic [CW-1:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  mseq_dispatch_if #(.DATA_WIDTH(DW), .INPUT_DATA_WIDTH(IDW), .N_CH(N)) bus ();

  mseq_dispatch #(.DATA_WIDTH(DW), .INPUT_DATA_WIDTH(IDW), .N_CH(N), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .word_pending(word_pending),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [IDW-1:0] got, input logic [IDW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*DW-1:0] smp(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {{8{8'h10 + b}}, {8{8'h20 + b}}, {8{8'h30 + b}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k);
    {bus.xn1, bus.yn1, bus.zn1} = smp(k);
    bus.n1_valid = 1'b1;
    tick();
    bus.n1_valid = 1'b0;
  endtask

  task automatic setup(input logic [N-1:0] en, input logic [N-1:0] rdy, input logic mode);
    rst = 1'b1;
    bus.ch_en = en;
    bus.ch_ready = rdy;
    bus.bcast_mode = mode;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3*DW-1:0] s0, s1, s2;
    logic [N-1:0] rr_exp [3];
    int w;
    s0 = smp(0);
    s1 = smp(1);
    s2 = smp(2);
    rr_exp[0] = 4'b0010;
    rr_exp[1] = 4'b1000;
    rr_exp[2] = 4'b0010;
    bus.n1_valid = 1'b0;
    bus.xn1 = '0;
    bus.yn1 = '0;
    bus.zn1 = '0;

    setup(4'b1111, 4'b1111, MODE_RR);
    check("rst_din", bus.mseq_din, '0);
    check("rst_vld", IDW'(bus.mseq_din_vld), '0);
    check("rst_pend", IDW'(word_pending), '0);
    check("rst_ovf", IDW'(overflow), '0);
    check("rst_drop", IDW'(drop_cnt), '0);
    send(0);
    check("t1_s0_vld", IDW'(bus.mseq_din_vld), '0);
    check("t1_s0_pend", IDW'(word_pending), '0);
    send(1);
    check("t1_w1_din", bus.mseq_din, {s0, s1[191:96]});
    check("t1_w1_pend", IDW'(word_pending), 1);
    check("t1_w1_novld", IDW'(bus.mseq_din_vld), '0);
    tick();
    check("t1_w1_vld", IDW'(bus.mseq_din_vld), 4'b0001);
    check("t1_w1_din_stable", bus.mseq_din, {s0, s1[191:96]});
    tick();
    check("t1_w1_vld_off", IDW'(bus.mseq_din_vld), '0);
    send(2);
    check("t1_w2_din", bus.mseq_din, {s1[95:0], s2});
    tick();
    check("t1_w2_vld", IDW'(bus.mseq_din_vld), 4'b0010);

    setup(4'b1010, 4'b1111, MODE_RR);
    w = 0;
    for (int k = 0; k < 5; k++) begin
      send(k);
      if (k == 1 || k == 2 || k == 4) begin
        tick();
        check($sformatf("t2_rr_w%0d", w), IDW'(bus.mseq_din_vld), IDW'(rr_exp[w]));
        w++;
      end
    end

    setup(4'b0111, 4'b1011, MODE_BCAST);
    send(0);
    send(1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t3_wait%0d", c), IDW'(bus.mseq_din_vld), '0);
    end
    bus.ch_ready = 4'b1111;
    tick();
    check("t3_bcast_vld", IDW'(bus.mseq_din_vld), 4'b0111);
    tick();
    check("t3_bcast_off", IDW'(bus.mseq_din_vld), '0);
    bus.bcast_mode = MODE_RR;
    bus.ch_en = 4'b1111;
    send(2);
    tick();
    check("t3_ptr_kept", IDW'(bus.mseq_din_vld), 4'b0001);

    setup(4'b1111, 4'b0000, MODE_RR);
    for (int k = 0; k < 6; k++) send(k);
    check("t4_drop", IDW'(drop_cnt), 3);
    check("t4_ovf", IDW'(overflow), 1);
    check("t4_pend", IDW'(word_pending), 1);
    check("t4_din", bus.mseq_din, {s0, s1[191:96]});
    bus.ch_ready = 4'b1111;
    tick();
    check("t4_vld", IDW'(bus.mseq_din_vld), 4'b0001);
    check("t4_din_sent", bus.mseq_din, {s0, s1[191:96]});

    setup(4'b1111, 4'b0000, MODE_RR);
    send(0);
    send(1);
    check("t5_pend_before", IDW'(word_pending), 1);
    bus.ch_en = 4'b0000;
    tick();
    check("t5_drop", IDW'(drop_cnt), 1);
    check("t5_ovf", IDW'(overflow), 1);
    check("t5_pend_after", IDW'(word_pending), 0);
    check("t5_vld", IDW'(bus.mseq_din_vld), '0);
    tick();
    check("t5_vld_late", IDW'(bus.mseq_din_vld), '0);

    setup(4'b1111, 4'b0000, MODE_RR);
    send(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_pend_rst", IDW'(word_pending), 0);
    send(1);
    check("t6_no_word", IDW'(word_pending), 0);
    send(2);
    check("t6_din", bus.mseq_din, {s1, s2[191:96]});
    check("t6_pend", IDW'(word_pending), 1);

    setup(4'b1111, 4'b1111, MODE_RR);
    send(0);
    send(1);
    send(2);
    check("t7_vld_old", IDW'(bus.mseq_din_vld), 4'b0001);
    check("t7_din_old", bus.mseq_din, {s0, s1[191:96]});
    check("t7_pend", IDW'(word_pending), 1);
    tick();
    check("t7_din_new", bus.mseq_din, {s1[95:0], s2});
    check("t7_vld_new", IDW'(bus.mseq_din_vld), 4'b0010);
    check("t7_drop", IDW'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
